// File: rtl/axi4_mem_ctrl_if.sv
// AXI4 bus between an interconnect master and the axi4_mem_ctrl slave.
// Write strobes are omitted because the slave only performs full-word writes.
interface axi4_mem_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;

  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WLAST, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WLAST, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi4_mem_ctrl.sv
// AXI4 slave front-end for a single-port word memory: one transaction at a time,
// INCR bursts of 32-bit words only, anything else answered with SLVERR.
module axi4_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DEPTH          = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  axi4_mem_ctrl_if.slave            axi,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);
  localparam int SUM_W = MEM_ADDR_WIDTH + 9;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_MEM, RD_CAP, RD_DATA} state_t;

  state_t                    state, state_nx;
  logic [MEM_ADDR_WIDTH-1:0] idx;
  logic [7:0]                beat, len;
  logic                      err, last_err;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [1:0]                rresp_q;
  logic                      rlast_q;
  logic                      aw_hs, ar_hs, final_beat;

  function automatic logic burst_bad(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] blen,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [SUM_W-1:0] last_word;
    last_word = SUM_W'(addr >> 2) + SUM_W'(blen);
    return (burst != 2'b01) || (size != 3'b010) || (addr[1:0] != 2'b00) ||
           (last_word >= SUM_W'(DEPTH));
  endfunction

  // Writes win over reads in IDLE, so ARREADY is withheld while AWVALID is up
  // to keep a simultaneous AR from completing a handshake that is not served.
  assign axi.AWREADY = (state == IDLE) && !ARESET;
  assign axi.ARREADY = (state == IDLE) && !ARESET && !axi.AWVALID;
  assign aw_hs       = axi.AWVALID && axi.AWREADY;
  assign ar_hs       = axi.ARVALID && axi.ARREADY;
  assign final_beat  = (beat == len);

  assign axi.WREADY  = (state == WR_DATA);
  assign axi.BVALID  = (state == WR_RESP);
  assign axi.BRESP   = (axi.BVALID && (err || last_err)) ? 2'b10 : 2'b00;
  assign axi.RVALID  = (state == RD_DATA);
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = rresp_q;
  assign axi.RLAST   = rlast_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nx  = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (aw_hs)      state_nx = WR_DATA;
        else if (ar_hs) state_nx = RD_MEM;
      end
      WR_DATA: begin
        if (axi.WVALID) begin
          mem_en    = !err;
          mem_we    = !err;
          mem_addr  = err ? '0 : idx;
          mem_wdata = err ? '0 : axi.WDATA;
          if (final_beat) state_nx = WR_RESP;
        end
      end
      WR_RESP: if (axi.BREADY) state_nx = IDLE;
      RD_MEM: begin
        mem_en   = !err;
        mem_addr = err ? '0 : idx;
        state_nx = RD_CAP;
      end
      RD_CAP:  state_nx = RD_DATA;
      RD_DATA: if (axi.RREADY) state_nx = rlast_q ? IDLE : RD_MEM;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      idx      <= '0;
      beat     <= '0;
      len      <= '0;
      err      <= 1'b0;
      last_err <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            idx      <= axi.AWADDR[MEM_ADDR_WIDTH+1:2];
            len      <= axi.AWLEN;
            err      <= burst_bad(axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST);
            last_err <= 1'b0;
            beat     <= '0;
          end else if (ar_hs) begin
            idx      <= axi.ARADDR[MEM_ADDR_WIDTH+1:2];
            len      <= axi.ARLEN;
            err      <= burst_bad(axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST);
            last_err <= 1'b0;
            beat     <= '0;
          end
        end
        WR_DATA: begin
          if (axi.WVALID) begin
            if (axi.WLAST != final_beat) last_err <= 1'b1;
            beat <= beat + 8'd1;
            idx  <= idx + MEM_ADDR_WIDTH'(1);
          end
        end
        RD_CAP: begin
          rdata_q <= err ? '0 : mem_rdata;
          rresp_q <= err ? 2'b10 : 2'b00;
          rlast_q <= final_beat;
        end
        RD_DATA: begin
          if (axi.RREADY && !rlast_q) begin
            beat <= beat + 8'd1;
            idx  <= idx + MEM_ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/axi4_mem_ctrl.md
# axi4_mem_ctrl

AXI4 slave front-end that accepts AXI4 read and write bursts and drives the single-port memory request interface (`mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_rdata`) of the backing 1024×32 memory. It serves one transaction at a time, validates every burst, and returns OKAY or SLVERR on B/R. It sits between the AXI interconnect/testbench master and the memory array.

## Interface
- `DATA_WIDTH`, 32: AXI data and memory word width.
- `ADDR_WIDTH`, 16: AXI byte-address width.
- `MEM_ADDR_WIDTH`, 10: memory word-index width.
- `DEPTH`, 1024: memory words.
- `ACLK` in 1: clock; all logic on rising edge.
- `ARESET` in 1: asynchronous, active-high reset.
- `AWADDR` in ADDR_WIDTH, `AWLEN` in 8, `AWSIZE` in 3, `AWBURST` in 2, `AWVALID` in 1, `AWREADY` out 1: write address channel.
- `WDATA` in DATA_WIDTH, `WLAST` in 1, `WVALID` in 1, `WREADY` out 1: write data channel. No strobes; full-word writes only.
- `BRESP` out 2, `BVALID` out 1, `BREADY` in 1: write response.
- `ARADDR` in ADDR_WIDTH, `ARLEN` in 8, `ARSIZE` in 3, `ARBURST` in 2, `ARVALID` in 1, `ARREADY` out 1: read address channel.
- `RDATA` out DATA_WIDTH, `RRESP` out 2, `RLAST` out 1, `RVALID` out 1, `RREADY` in 1: read data channel.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out MEM_ADDR_WIDTH, `mem_wdata` out DATA_WIDTH: memory request.
- `mem_rdata` in DATA_WIDTH: memory read data, registered inside the memory, valid the cycle after a read request.

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_MEM, RD_CAP, RD_DATA.
- IDLE: `AWREADY`=`ARREADY`=1. If `AWVALID` is high, the write is accepted and the read is not, even when `ARVALID` is also high. Otherwise `ARVALID` is accepted. Address, length, and error flag are latched at the handshake.
- Burst check, applied to both AW and AR. The burst is errored when any of these holds:
  - BURST≠2'b01 (INCR);
  - SIZE≠3'b010;
  - ADDR[1:0]≠0;
  - (ADDR>>2)+LEN ≥ DEPTH, computed at MEM_ADDR_WIDTH+9 bits with no wrap.
- Word index starts at ADDR[MEM_ADDR_WIDTH+1:2] and increments by 1 per beat.
- WR_DATA:
  - `WREADY`=1.
  - Each W handshake drives `mem_en`=`mem_we`=1, `mem_addr`=index, `mem_wdata`=`WDATA`, combinationally in the same cycle.
  - For an errored burst, W beats are still accepted but `mem_en` stays 0.
  - The beat counter runs 0..LEN. The burst ends on beat LEN, then the FSM goes to WR_RESP.
  - If `WLAST` does not match (beat==LEN), the response becomes SLVERR. Data is still written for a valid burst.
- WR_RESP: `BVALID`=1 with `BRESP`=2'b00 OKAY or 2'b10 SLVERR. On `BREADY`, return to IDLE.
- RD_MEM:
  - Valid burst: `mem_en`=1, `mem_we`=0, `mem_addr`=index.
  - Errored burst: `mem_en`=0.
  - Next state RD_CAP.
- RD_CAP: at end of cycle, load `RDATA`←`mem_rdata` (0 if errored), `RRESP`, and `RLAST`=(beat==LEN). Set `RVALID`. Go to RD_DATA.
- RD_DATA: hold `RDATA`, `RRESP`, `RLAST` stable while `RVALID`=1 and `RREADY`=0. On handshake, clear `RVALID`. If `RLAST`, go to IDLE; else increment index and beat and go to RD_MEM.
- An errored read returns LEN+1 beats of SLVERR with `RDATA`=0.
- `mem_en` is 0 in every state and condition not listed above.

## Timing
- Reset values: `AWREADY`=`ARREADY`=0 while `ARESET` is high, then 1 from the first cycle after release. All other outputs are 0 and the FSM is IDLE.
- Reset mid-burst: outputs clear immediately (asynchronously). Beats already written stay in memory. No response is issued.
- Write: AW handshake at edge k → `WREADY`=1 in cycle k. The last W handshake at edge m → `BVALID`=1 from cycle m onward.
- Read: AR handshake at edge k → `mem_en` in cycle k → `RVALID`=1 from edge k+2.
- With `RREADY` held high, a read runs at one beat per 3 cycles.
- A write runs at one beat per cycle when `WVALID` is held high.
- The next AW/AR is accepted no earlier than the cycle after the B or final R handshake, when `AWREADY`/`ARREADY` return to 1.
- `BVALID` and `RVALID` never drop without a handshake.

## Test plan
- Single write then read:
  - AW 0x0010, LEN=0, WDATA=0xDEADBEEF → `mem_addr`=4 written, BRESP=OKAY.
  - AR 0x0010 → RDATA=0xDEADBEEF, RLAST=1, RVALID 2 cycles after AR.
- INCR burst: write LEN=3 at 0x0FF0 with data 1,2,3,4 → words 1020..1023 written.
  - Read back with RREADY toggling every other cycle → 1,2,3,4 in order, RLAST only on beat 4, RDATA stable while stalled.
- Out-of-range: AW 0x0FF4, LEN=3 → 4 W beats accepted, no `mem_en`, BRESP=SLVERR.
  - AR at the same address → 4 beats of SLVERR, RDATA=0.
- Bad attributes:
  - ARBURST=FIXED → SLVERR.
  - AWSIZE=1 → SLVERR.
  - AWADDR=0x0002 → SLVERR.
  - WLAST asserted on beat 1 of LEN=2 → data written, BRESP=SLVERR.
- Simultaneous AWVALID and ARVALID in IDLE → write accepted first, `ARREADY` low until B completes, then read served.
- Reset asserted during beat 2 of a LEN=3 write → all outputs 0 immediately.
  - After release, an AR of the same range returns beats 0–1 new, beats 2–3 old.
